// File: rtl/spi_reg_slave.sv
// spi_reg_slave: SPI mode-0 responder exposing a 2^ADDR_W x 8 register bank.
//
// SCLK/SS/MOSI are oversampled in the GCLK domain. The first byte of a frame
// is a command (bit7 = read, low ADDR_W bits = start address). The remaining
// bytes are either written to the bank or read back on MISO.
//
// Build option: define SPI_SLAVE_AUTOINC_EN to make bursts step through
// consecutive addresses. The step wraps from 2^ADDR_W-1 to 0. Without it,
// every data byte of a frame uses the start address.
//
// Ports:
//   GCLK, RST      system clock; asynchronous active-high reset
//   SLAVE_SCLK     SPI clock (asynchronous to GCLK)
//   SLAVE_SS       active-low slave select
//   SLAVE_MOSI     master-to-slave data, MSB first
//   SLAVE_MISO     slave-to-master data, MSB first; 0 when not reading
//   LOC_ADDR       local read address
//   LOC_DATA       bank[LOC_ADDR], combinational
//   WR_STB         one-cycle pulse per committed SPI write
//   WR_ADDR        address of the last committed write
//   WR_DATA        data of the last committed write
//   FRAME_DONE     one-cycle pulse when SS rises after a started frame
module spi_reg_slave #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 8
) (
  input  logic              GCLK,
  input  logic              RST,
  input  logic              SLAVE_SCLK,
  input  logic              SLAVE_SS,
  input  logic              SLAVE_MOSI,
  output logic              SLAVE_MISO,
  input  logic [ADDR_W-1:0] LOC_ADDR,
  output logic [DATA_W-1:0] LOC_DATA,
  output logic              WR_STB,
  output logic [ADDR_W-1:0] WR_ADDR,
  output logic [DATA_W-1:0] WR_DATA,
  output logic              FRAME_DONE
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int          CNT_W = $clog2(DATA_W);

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    DATA
  } state_t;

  // Synchronizers: two stages for metastability, a third for edge detect.
  logic [2:0] sclk_sync;
  logic [2:0] ss_sync;
  logic [1:0] mosi_sync;

  // SS stages reset low. If reset is released while SS is held low, no fall
  // is seen, so a frame only starts after SS has been high again. A rise
  // seen right after reset lands in IDLE with no frame open and is harmless.
  always_ff @(posedge GCLK or posedge RST) begin
    if (RST) begin
      sclk_sync <= '0;
      ss_sync   <= '0;
      mosi_sync <= '0;
    end else begin
      sclk_sync <= {sclk_sync[1:0], SLAVE_SCLK};
      ss_sync   <= {ss_sync[1:0], SLAVE_SS};
      mosi_sync <= {mosi_sync[0], SLAVE_MOSI};
    end
  end

  logic sclk_rise, sclk_fall, ss_rise, ss_fall, mosi_bit;
  assign sclk_rise = sclk_sync[1] & ~sclk_sync[2];
  assign sclk_fall = ~sclk_sync[1] & sclk_sync[2];
  assign ss_rise   = ss_sync[1] & ~ss_sync[2];
  assign ss_fall   = ~ss_sync[1] & ss_sync[2];
  assign mosi_bit  = mosi_sync[1];

  state_t             state;
  logic [CNT_W-1:0]   bit_cnt;
  logic [DATA_W-1:0]  rx;
  logic [DATA_W-1:0]  tx;
  logic [ADDR_W-1:0]  addr;
  logic               read;
  logic               in_frame;
  logic [DATA_W-1:0]  bank [DEPTH];

  logic [DATA_W-1:0]  rx_next;
  logic [ADDR_W-1:0]  cmd_addr;
  logic [ADDR_W-1:0]  addr_nxt;
  logic               last_bit;

  assign rx_next  = {rx[DATA_W-2:0], mosi_bit};
  assign cmd_addr = rx_next[ADDR_W-1:0];
  assign last_bit = (bit_cnt == CNT_W'(DATA_W - 1));

`ifdef SPI_SLAVE_AUTOINC_EN
  assign addr_nxt = addr + ADDR_W'(1);
`else
  assign addr_nxt = addr;
`endif

  assign LOC_DATA = bank[LOC_ADDR];

  always_ff @(posedge GCLK or posedge RST) begin
    if (RST) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      rx         <= '0;
      tx         <= '0;
      addr       <= '0;
      read       <= 1'b0;
      in_frame   <= 1'b0;
      SLAVE_MISO <= 1'b0;
      WR_STB     <= 1'b0;
      WR_ADDR    <= '0;
      WR_DATA    <= '0;
      FRAME_DONE <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        bank[i] <= '0;
      end
    end else begin
      WR_STB     <= 1'b0;
      FRAME_DONE <= 1'b0;
      if (ss_rise) begin
        // End of frame. Any partial byte is dropped without a write.
        state      <= IDLE;
        bit_cnt    <= '0;
        tx         <= '0;
        SLAVE_MISO <= 1'b0;
        FRAME_DONE <= in_frame;
        in_frame   <= 1'b0;
      end else if (ss_fall) begin
        state      <= CMD;
        bit_cnt    <= '0;
        rx         <= '0;
        tx         <= '0;
        SLAVE_MISO <= 1'b0;
        in_frame   <= 1'b1;
      end else if (state != IDLE) begin
        if (sclk_rise) begin
          rx      <= rx_next;
          bit_cnt <= bit_cnt + CNT_W'(1);
          if (last_bit) begin
            if (state == CMD) begin
              state <= DATA;
              read  <= rx_next[DATA_W-1];
              addr  <= cmd_addr;
              if (rx_next[DATA_W-1]) begin
                tx         <= bank[cmd_addr];
                SLAVE_MISO <= bank[cmd_addr][DATA_W-1];
              end
            end else begin
              addr <= addr_nxt;
              if (read) begin
                tx         <= bank[addr_nxt];
                SLAVE_MISO <= bank[addr_nxt][DATA_W-1];
              end else begin
                bank[addr] <= rx_next;
                WR_STB     <= 1'b1;
                WR_ADDR    <= addr;
                WR_DATA    <= rx_next;
              end
            end
          end
        end else if (sclk_fall && state == DATA && read && bit_cnt != '0) begin
          // The fall that follows a byte's 8th rise has bit_cnt == 0. At
          // that point the freshly loaded MSB must stay on MISO.
          tx         <= {tx[DATA_W-2:0], 1'b0};
          SLAVE_MISO <= tx[DATA_W-2];
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_reg_slave.sv
// Bench for spi_reg_slave: directed vector table, hand-written corner
// sequences (partial byte, reset mid-frame) and random frames checked
// against a register-bank model of the SPI protocol.
module tb_spi_reg_slave;

  localparam int HALF = 8;

  logic       gclk;
  logic       rst;
  logic       sclk;
  logic       ss;
  logic       mosi;
  logic       miso;
  logic [2:0] loc_addr;
  logic [7:0] loc_data;
  logic       wr_stb;
  logic [2:0] wr_addr;
  logic [7:0] wr_data;
  logic       frame_done;

  spi_reg_slave #(.ADDR_W(3), .DATA_W(8)) dut (
    .GCLK       (gclk),
    .RST        (rst),
    .SLAVE_SCLK (sclk),
    .SLAVE_SS   (ss),
    .SLAVE_MOSI (mosi),
    .SLAVE_MISO (miso),
    .LOC_ADDR   (loc_addr),
    .LOC_DATA   (loc_data),
    .WR_STB     (wr_stb),
    .WR_ADDR    (wr_addr),
    .WR_DATA    (wr_data),
    .FRAME_DONE (frame_done)
  );

  initial gclk = 1'b0;
  always #5 gclk = ~gclk;

  int checks = 0;
  int errors = 0;

  logic [10:0] wr_q[$];
  int          fd_cnt = 0;

  always @(negedge gclk) begin
    if (wr_stb) wr_q.push_back({wr_addr, wr_data});
    if (frame_done) fd_cnt++;
  end

  logic [7:0] mbank [8];
  logic [7:0] fo [8];
  logic [7:0] fi [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [2:0] next_addr(input logic [2:0] a);
`ifdef SPI_SLAVE_AUTOINC_EN
    return 3'((a + 1) % 8);
`else
    return a;
`endif
  endfunction

  task automatic spi_byte(input logic [7:0] o, input int nbits, output logic [7:0] i);
    i = '0;
    for (int k = 7; k > 7 - nbits; k--) begin
      mosi = o[k];
      repeat (HALF) @(negedge gclk);
      i[k] = miso;
      sclk = 1'b1;
      repeat (HALF) @(negedge gclk);
      sclk = 1'b0;
    end
  endtask

  task automatic check_bank(input string tag);
    for (int a = 0; a < 8; a++) begin
      loc_addr = 3'(a);
      #1;
      chk({tag, " loc_data"}, {24'd0, loc_data}, {24'd0, mbank[a]});
    end
  endtask

  // One frame: nfull whole bytes from fo[], then part_bits bits of fo[nfull].
  task automatic do_frame(input string tag, input int nfull, input int part_bits);
    logic [10:0] expw[$];
    logic [7:0]  exp_rx [8];
    logic [2:0]  a;
    logic [7:0]  tmp;
    int          fd0;
    for (int k = 0; k < 8; k++) begin
      exp_rx[k] = 8'h00;
      fi[k]     = 8'h00;
    end
    a = fo[0][2:0];
    for (int k = 1; k < nfull; k++) begin
      if (fo[0][7]) exp_rx[k] = mbank[a];
      else begin
        mbank[a] = fo[k];
        expw.push_back({a, fo[k]});
      end
      a = next_addr(a);
    end
    wr_q.delete();
    fd0 = fd_cnt;
    ss = 1'b0;
    repeat (HALF) @(negedge gclk);
    for (int k = 0; k < nfull; k++) begin
      spi_byte(fo[k], 8, tmp);
      fi[k] = tmp;
    end
    if (part_bits > 0) spi_byte(fo[nfull], part_bits, tmp);
    repeat (HALF) @(negedge gclk);
    ss = 1'b1;
    repeat (12) @(negedge gclk);
    chk({tag, " wr_count"}, wr_q.size(), expw.size());
    for (int k = 0; k < expw.size() && k < wr_q.size(); k++)
      chk({tag, " wr_entry"}, {21'd0, wr_q[k]}, {21'd0, expw[k]});
    for (int k = 0; k < nfull; k++)
      chk({tag, " miso_byte"}, {24'd0, fi[k]}, {24'd0, exp_rx[k]});
    chk({tag, " frame_done"}, fd_cnt - fd0, 1);
    chk({tag, " miso_idle"}, {31'd0, miso}, 0);
  endtask

  typedef struct {
    logic [7:0] b0, b1, b2;
    int         n;
    int         exp_wr;
    logic [7:0] rx1, rx2;
    logic [2:0] ca0;
    logic [7:0] cd0;
    logic [2:0] ca1;
    logic [7:0] cd1;
    logic [2:0] wa;
    logic [7:0] wd;
  } vec_t;

  vec_t tbl [4];

  initial begin
    logic [7:0] tmp;
    int         fd0;
    int         nfull;
    int         part;

    tbl[0] = '{8'h03, 8'hA5, 8'h00, 2, 1, 8'h00, 8'h00, 3'd3, 8'hA5, 3'd2, 8'h00, 3'd3, 8'hA5};
    tbl[1] = '{8'h83, 8'h00, 8'h00, 2, 0, 8'hA5, 8'h00, 3'd3, 8'hA5, 3'd4, 8'h00, 3'd3, 8'hA5};
`ifdef SPI_SLAVE_AUTOINC_EN
    tbl[2] = '{8'h07, 8'h11, 8'h22, 3, 2, 8'h00, 8'h00, 3'd7, 8'h11, 3'd0, 8'h22, 3'd0, 8'h22};
    tbl[3] = '{8'h87, 8'h00, 8'h00, 3, 0, 8'h11, 8'h22, 3'd7, 8'h11, 3'd0, 8'h22, 3'd0, 8'h22};
`else
    tbl[2] = '{8'h07, 8'h11, 8'h22, 3, 2, 8'h00, 8'h00, 3'd7, 8'h22, 3'd0, 8'h00, 3'd7, 8'h22};
    tbl[3] = '{8'h87, 8'h00, 8'h00, 3, 0, 8'h22, 8'h22, 3'd7, 8'h22, 3'd0, 8'h00, 3'd7, 8'h22};
`endif

    rst = 1'b1;
    sclk = 1'b0;
    ss = 1'b1;
    mosi = 1'b0;
    loc_addr = '0;
    for (int a = 0; a < 8; a++) mbank[a] = 8'h00;
    repeat (4) @(negedge gclk);
    rst = 1'b0;
    repeat (6) @(negedge gclk);

    chk("reset miso", {31'd0, miso}, 0);
    chk("reset wr_stb", {31'd0, wr_stb}, 0);
    chk("reset frame_done", {31'd0, frame_done}, 0);
    chk("reset wr_addr", {29'd0, wr_addr}, 0);
    chk("reset wr_data", {24'd0, wr_data}, 0);
    chk("reset fd_cnt", fd_cnt, 0);
    check_bank("reset");

    for (int i = 0; i < 4; i++) begin
      fo[0] = tbl[i].b0;
      fo[1] = tbl[i].b1;
      fo[2] = tbl[i].b2;
      do_frame("vec", tbl[i].n, 0);
      chk("vec wr_stb_count", wr_q.size(), tbl[i].exp_wr);
      chk("vec rx1", {24'd0, fi[1]}, {24'd0, tbl[i].rx1});
      chk("vec rx2", {24'd0, fi[2]}, {24'd0, tbl[i].rx2});
      loc_addr = tbl[i].ca0;
      #1;
      chk("vec loc0", {24'd0, loc_data}, {24'd0, tbl[i].cd0});
      loc_addr = tbl[i].ca1;
      #1;
      chk("vec loc1", {24'd0, loc_data}, {24'd0, tbl[i].cd1});
      chk("vec wr_addr", {29'd0, wr_addr}, {29'd0, tbl[i].wa});
      chk("vec wr_data", {24'd0, wr_data}, {24'd0, tbl[i].wd});
    end

    // Command then half a data byte: nothing may be written.
    fo[0] = 8'h02;
    fo[1] = 8'hF0;
    do_frame("partial", 1, 4);
    check_bank("partial");
    fo[1] = 8'h5A;
    do_frame("after_partial", 2, 0);
    loc_addr = 3'd2;
    #1;
    chk("after_partial loc2", {24'd0, loc_data}, 32'h5A);

    // Reset in the middle of a write data byte, released with SS still low.
    wr_q.delete();
    ss = 1'b0;
    repeat (HALF) @(negedge gclk);
    spi_byte(8'h05, 8, tmp);
    spi_byte(8'hC3, 4, tmp);
    rst = 1'b1;
    repeat (3) @(negedge gclk);
    rst = 1'b0;
    for (int a = 0; a < 8; a++) mbank[a] = 8'h00;
    fd0 = fd_cnt;
    wr_q.delete();
    spi_byte(8'hFF, 8, tmp);
    spi_byte(8'h81, 8, tmp);
    repeat (HALF) @(negedge gclk);
    ss = 1'b1;
    repeat (12) @(negedge gclk);
    chk("rst_mid wr_count", wr_q.size(), 0);
    chk("rst_mid frame_done", fd_cnt - fd0, 0);
    chk("rst_mid wr_addr", {29'd0, wr_addr}, 0);
    chk("rst_mid wr_data", {24'd0, wr_data}, 0);
    check_bank("rst_mid");
    fo[0] = 8'h05;
    fo[1] = 8'h3C;
    do_frame("post_rst", 2, 0);
    check_bank("post_rst");

    for (int f = 0; f < 30; f++) begin
      nfull = $urandom_range(1, 4);
      part = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
      for (int k = 0; k < 8; k++) fo[k] = 8'($urandom);
      do_frame("rand", nfull, part);
    end
    check_bank("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
